regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file. Next generation of the CPU's 32x32 regfile.
- Generalised in data width, depth and read-port count.
- Adds a second write port with defined priority, a hardware soft-clear sequencer with busy/done handshake, and optional write-to-read bypass.
- Sits in the decode/writeback boundary of the CPU datapath.

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on address clash), N_RD
// combinational read ports, and a soft-clear sequencer with a busy/done handshake.
// Define REGFILE_MP_BYPASS_EN to forward accepted write data to matching read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                clr_done_q, clr_done_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic wr0_acc, wr1_acc, wr_attempt, clr_wr;

    assign busy       = (state_q == CLEAR);
    assign clr_done   = clr_done_q;
    assign wr_drop    = wr_drop_q;

    // Address 0 never qualifies, so regs_q[0] stays at its reset value of zero.
    assign wr0_acc    = ena && !busy && we0 && (waddr0 != '0);
    assign wr1_acc    = ena && !busy && we1 && (waddr1 != '0);
    assign wr_attempt = (we0 && (waddr0 != '0)) || (we1 && (waddr1 != '0));
    assign clr_wr     = busy && ena;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        wr_drop_d  = busy && wr_attempt;
        case (state_q)
            IDLE: begin
                if (ena && clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = PTR_FIRST;
                end
            end
            CLEAR: begin
                if (ena) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d    = IDLE;
                        ptr_d      = PTR_FIRST;
                        clr_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = PTR_FIRST;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_FIRST;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // NOTE: the array is reset because software relies on reset-to-zero registers; this keeps it in flops rather than RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (clr_wr) begin
                regs_q[ptr_q] <= '0;
            end
            if (wr0_acc) begin
                regs_q[waddr0] <= wdata0;
            end
            // Issued after port 0 so that port 1 wins when both target one address.
            if (wr1_acc) begin
                regs_q[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = '0;
            if (ena && (rd_addr != '0)) begin
                rd_val = regs_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
                if (wr0_acc && (waddr0 == rd_addr)) begin
                    rd_val = wdata0;
                end
                if (wr1_acc && (waddr1 == rd_addr)) begin
                    rd_val = wdata1;
                end
`else
`endif
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ena;
    logic                   we0, we1;
    logic [ADDR_W-1:0]      waddr0, waddr1;
    logic [DATA_W-1:0]      wdata0, wdata1;
    logic [N_RD*ADDR_W-1:0] raddr;
    logic [N_RD*DATA_W-1:0] rdata;
    logic                   clr_req;
    logic                   busy, clr_done, wr_drop;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, number of registers still to clear,
    // and the two registered flags.
    logic [DATA_W-1:0] m_reg [DEPTH];
    int                m_left;
    logic              m_done, m_drop;

    function automatic logic m_busy();
        return m_left != 0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input int k);
        logic [ADDR_W-1:0] a;
        a = raddr[k*ADDR_W +: ADDR_W];
        if (!ena || a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy() && we1 && waddr1 == a) return wdata1;
        if (!m_busy() && we0 && waddr0 == a) return wdata0;
`endif
        return m_reg[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
            m_left = 0;
            m_done = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_drop = m_busy() && ((we0 && waddr0 != 0) || (we1 && waddr1 != 0));
            m_done = m_busy() && ena && (m_left == 1);
            if (m_busy()) begin
                if (ena) begin
                    m_reg[DEPTH - m_left] = '0;
                    m_left--;
                end
            end else if (ena) begin
                if (we0 && waddr0 != 0) m_reg[waddr0] = wdata0;
                if (we1 && waddr1 != 0) m_reg[waddr1] = wdata1;
                if (clr_req) m_left = DEPTH - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N_RD; k++) begin
            check($sformatf("model_rdata%0d", k), 64'(rdata[k*DATA_W +: DATA_W]), 64'(exp_rd(k)));
        end
        check("model_busy", 64'(busy), 64'(m_busy()));
        check("model_clr_done", 64'(clr_done), 64'(m_done));
        check("model_wr_drop", 64'(wr_drop), 64'(m_drop));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int k, input int a);
        raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic write(input int port, input int a, input logic [DATA_W-1:0] d);
        if (port == 0) begin
            we0 = 1'b1; waddr0 = ADDR_W'(a); wdata0 = d;
        end else begin
            we1 = 1'b1; waddr1 = ADDR_W'(a); wdata1 = d;
        end
    endtask

    task automatic no_write();
        we0 = 1'b0; we1 = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int k);
        return rdata[k*DATA_W +: DATA_W];
    endfunction

    int cnt;
    int done_seen;

    initial begin
        rst_n = 1'b1; ena = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr = '0;
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Reset mid-operation: a write is in flight when reset hits.
        write(0, 5, 32'h0000_0001);
        set_rd(0, 5);
        step();
        check("pre_reset_r5", 64'(rd(0)), 64'h1);
        rst_n = 1'b0;
        #1;
        check("reset_rdata0", 64'(rd(0)), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        no_write();
        step();
        rst_n = 1'b1;

        // Basic write/read through port 0.
        write(0, 5, 32'hDEAD_BEEF);
        step();
        no_write();
        #1;
        check("r5_deadbeef", 64'(rd(0)), 64'hDEAD_BEEF);

        // Same-address conflict: port 1 wins.
        write(0, 7, 32'h1111_1111);
        write(1, 7, 32'h2222_2222);
        step();
        no_write();
        write(0, 0, 32'hFFFF_FFFF);
        step();
        no_write();
        set_rd(0, 7); set_rd(1, 0);
        #1;
        check("r7_port1_wins", 64'(rd(0)), 64'h2222_2222);
        check("r0_hardwired", 64'(rd(1)), 64'h0);
        check("r0_write_no_drop", 64'(wr_drop), 64'h0);

        // Two distinct addresses in the same cycle.
        write(0, 10, 32'hAAAA_0010);
        write(1, 11, 32'hBBBB_0011);
        step();
        no_write();
        set_rd(0, 10); set_rd(1, 11);
        #1;
        check("dual_r10", 64'(rd(0)), 64'hAAAA_0010);
        check("dual_r11", 64'(rd(1)), 64'hBBBB_0011);

        // Full clear sequence with a dropped write.
        write(0, 3, 32'hA5A5_A5A5);
        write(1, 31, 32'h5A5A_5A5A);
        step();
        no_write();
        set_rd(0, 3); set_rd(1, 31);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        cnt = 0;
        done_seen = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == 1) write(0, 9, 32'h9999_9999);
            if (cnt == 2) begin
                check("wr_drop_set", 64'(wr_drop), 64'h1);
                no_write();
                write(1, 0, 32'h1234_0000);
                clr_req = 1'b1;
            end
            if (cnt == 3) begin
                check("wr_drop_clear", 64'(wr_drop), 64'h0);
                no_write();
                clr_req = 1'b0;
            end
            if (clr_done) done_seen++;
            step();
        end
        check("busy_cycles", 64'(cnt), 64'd31);
        repeat (3) begin
            if (clr_done) done_seen++;
            step();
        end
        check("clr_done_pulses", 64'(done_seen), 64'd1);
        set_rd(0, 3); set_rd(1, 31);
        #1;
        check("cleared_r3", 64'(rd(0)), 64'h0);
        check("cleared_r31", 64'(rd(1)), 64'h0);
        set_rd(0, 9);
        #1;
        check("dropped_r9", 64'(rd(0)), 64'h0);

        // Clear with an ena pause, interrupted by reset at clear cycle 10.
        write(0, 5, 32'h0000_0055);
        write(1, 12, 32'h0000_CAFE);
        step();
        no_write();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (3) step();
        ena = 1'b0;
        repeat (3) step();
        check("busy_paused", 64'(busy), 64'h1);
        ena = 1'b1;
        repeat (6) step();
        set_rd(0, 12); set_rd(1, 5);
        #1;
        check("clear_above_ptr", 64'(rd(0)), 64'h0000_CAFE);
        check("clear_below_ptr", 64'(rd(1)), 64'h0);
        rst_n = 1'b0;
        #1;
        check("reset_in_clear_busy", 64'(busy), 64'h0);
        check("reset_in_clear_r12", 64'(rd(0)), 64'h0);
        step();
        check("reset_in_clear_no_done", 64'(clr_done), 64'h0);
        rst_n = 1'b1;
        step();
        check("after_reset_no_done", 64'(clr_done), 64'h0);
        check("after_reset_busy", 64'(busy), 64'h0);

        // Same-cycle visibility of a write, with and without bypass.
        write(0, 4, 32'h0000_0044);
        step();
        set_rd(0, 4);
        write(0, 4, 32'h1234_5678);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("bypass_same_cycle", 64'(rd(0)), 64'h1234_5678);
`else
        check("no_bypass_old_value", 64'(rd(0)), 64'h0000_0044);
`endif
        step();
        no_write();
        #1;
        check("r4_committed", 64'(rd(0)), 64'h1234_5678);

        // Bypass port priority and ena=0 read gating.
        write(0, 6, 32'h6666_0000);
        write(1, 6, 32'h6666_1111);
        set_rd(1, 6);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("bypass_port1_wins", 64'(rd(1)), 64'h6666_1111);
`else
        check("no_bypass_r6_empty", 64'(rd(1)), 64'h0);
`endif
        step();
        no_write();
        ena = 1'b0;
        #1;
        check("ena_low_rdata0", 64'(rd(0)), 64'h0);
        check("ena_low_rdata1", 64'(rd(1)), 64'h0);
        step();
        ena = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
